de0_nano_qsys_cpu_jtag_scan_master: RTL and testbench

DE0_NANO_QSYS_CPU_JTAG_SCAN_MASTER -- requirements
Module: DE0_NANO_QSYS_cpu_jtag_scan_master

---
 rtl/de0_nano_qsys_cpu_jtag_scan_master_pkg.sv | 17 +
 rtl/de0_nano_qsys_cpu_jtag_scan_master_tckgen.sv | 36 +++
 rtl/de0_nano_qsys_cpu_jtag_scan_master.sv | 131 +++++++++++++
 tb/tb_de0_nano_qsys_cpu_jtag_scan_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/de0_nano_qsys_cpu_jtag_scan_master_pkg.sv
// Shared definitions for the virtual JTAG scan master: FSM states and SLD identity.
package de0_nano_qsys_cpu_jtag_scan_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR
  } state_e;

  localparam int DEF_IR_WIDTH = 2;
  localparam int DEF_DR_WIDTH = 38;
  localparam int SLD_MFG_ID   = 70;
  localparam int SLD_TYPE_ID  = 34;

endpackage

// File: rtl/de0_nano_qsys_cpu_jtag_scan_master_tckgen.sv
// Scan clock generator: tck toggles every CLK_DIV clk cycles while i_run is high,
// and o_tck_rise/o_tck_fall flag the clk cycle whose closing edge moves tck.
module de0_nano_qsys_cpu_jtag_scan_master_tckgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_run,
  output logic o_tck,
  output logic o_tck_rise,
  output logic o_tck_fall
);

  logic [7:0] r_cnt;
  logic       r_tck;
  logic       w_wrap;

  assign w_wrap     = i_run && (r_cnt == 8'(CLK_DIV - 1));
  assign o_tck_rise = w_wrap && !r_tck;
  assign o_tck_fall = w_wrap && r_tck;
  assign o_tck      = r_tck;

  // Parking at zero while idle guarantees every scan begins on a low tck phase.
  always_ff @(posedge clk) begin
    if (!reset_n || !i_run) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_tck <= !r_tck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/de0_nano_qsys_cpu_jtag_scan_master.sv
// Virtual JTAG scan master: runs one IR update or one DR scan per accepted command.
// Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready.
module de0_nano_qsys_cpu_jtag_scan_master
  import de0_nano_qsys_cpu_jtag_scan_master_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int IR_WIDTH = DEF_IR_WIDTH,
  parameter int DR_WIDTH = DEF_DR_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_is_ir,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                jtag_state_rti,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr
);

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  state_e                r_state;
  state_e                w_next_state;
  logic                  w_run;
  logic                  w_tck_rise;
  logic                  w_tck_fall;
  logic                  w_accept;
  logic                  w_last_bit;
  logic [DR_WIDTH-1:0]   r_shift;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_rsp_valid;
  logic                  r_ready_en;
  logic                  r_tdi;
  logic [IR_WIDTH-1:0]   r_ir_in;
  logic [IR_WIDTH-1:0]   r_rsp_ir;
  logic [DR_WIDTH-1:0]   r_rsp_dr;

  assign w_run      = (r_state != ST_IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_last_bit = (r_bit_cnt == BW'(DR_WIDTH - 1));

  de0_nano_qsys_cpu_jtag_scan_master_tckgen #(
    .CLK_DIV(CLK_DIV)
  ) u_tckgen (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_run     (w_run),
    .o_tck     (tck),
    .o_tck_rise(w_tck_rise),
    .o_tck_fall(w_tck_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Every non-idle state ends on a tck falling edge, so strobes only move there.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = cmd_is_ir ? ST_UIR : ST_CDR;
      ST_UIR:  if (w_tck_fall) w_next_state = ST_IDLE;
      ST_CDR:  if (w_tck_fall) w_next_state = ST_SDR;
      ST_SDR:  if (w_tck_fall && w_last_bit) w_next_state = ST_UDR;
      ST_UDR:  if (w_tck_fall) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_ready_en  <= 1'b0;
      r_tdi       <= 1'b0;
      r_ir_in     <= '0;
      r_rsp_ir    <= '0;
      r_rsp_dr    <= '0;
    end else begin
      r_ready_en  <= 1'b1;
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        if (cmd_is_ir) r_ir_in <= cmd_ir;
        else           r_shift <= cmd_dr;
      end
      if (r_state == ST_SDR && w_tck_rise)
        r_shift <= {tdo, r_shift[DR_WIDTH-1:1]};
      // tdi is refreshed on falls so it is stable across the next rising edge.
      if ((r_state == ST_CDR || r_state == ST_SDR) && w_tck_fall)
        r_tdi <= r_shift[0];
      if (r_state == ST_SDR && w_tck_fall)
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BW'(1);
      if (r_state == ST_UIR && w_tck_fall) begin
        r_rsp_ir    <= ir_out;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == ST_UDR && w_tck_fall) begin
        r_rsp_dr    <= r_shift;
        r_rsp_valid <= 1'b1;
        r_tdi       <= 1'b0;
      end
    end
  end

  assign cmd_ready      = (r_state == ST_IDLE) && !r_rsp_valid && r_ready_en;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_dr         = r_rsp_dr;
  assign rsp_ir         = r_rsp_ir;
  assign ir_in          = r_ir_in;
  assign tdi            = r_tdi;
  assign jtag_state_rti = (r_state == ST_IDLE);
  assign vs_uir         = (r_state == ST_UIR);
  assign vs_cdr         = (r_state == ST_CDR);
  assign vs_sdr         = (r_state == ST_SDR);
  assign vs_udr         = (r_state == ST_UDR);

endmodule

// File: tb/tb_de0_nano_qsys_cpu_jtag_scan_master.sv
// Directed bench for the scan master: a vector table at CLK_DIV=2 plus hand
// sequences for back-to-back commands, mid-scan reset and a CLK_DIV=1 instance.
module tb_de0_nano_qsys_cpu_jtag_scan_master;
  import de0_nano_qsys_cpu_jtag_scan_master_pkg::*;

  localparam int IRW = 2;
  localparam int DRW = 38;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- CLK_DIV=2 instance ----------------
  logic           cmd_valid, cmd_ready, cmd_is_ir;
  logic [IRW-1:0] cmd_ir, ir_in, ir_out, rsp_ir;
  logic [DRW-1:0] cmd_dr, rsp_dr;
  logic           rsp_valid, tck, tdi, tdo;
  logic           rti, vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic [1:0]     tdo_mode;

  assign tdo = (tdo_mode == 2'd0) ? tdi : tdo_mode[0];

  de0_nano_qsys_cpu_jtag_scan_master #(.CLK_DIV(2), .IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_ir(cmd_is_ir), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
    .rsp_dr(rsp_dr), .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out),
    .rsp_ir(rsp_ir), .jtag_state_rti(rti), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
    .vs_sdr(vs_sdr), .vs_udr(vs_udr)
  );

  // ---------------- CLK_DIV=1 instance, tdo tied high ----------------
  logic           d1_cmd_valid, d1_cmd_ready, d1_cmd_is_ir;
  logic [IRW-1:0] d1_cmd_ir, d1_ir_in, d1_rsp_ir;
  logic [DRW-1:0] d1_cmd_dr, d1_rsp_dr;
  logic           d1_rsp_valid, d1_tck, d1_tdi;
  logic           d1_rti, d1_vs_uir, d1_vs_cdr, d1_vs_sdr, d1_vs_udr;

  de0_nano_qsys_cpu_jtag_scan_master #(.CLK_DIV(1), .IR_WIDTH(IRW), .DR_WIDTH(DRW)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready),
    .cmd_is_ir(d1_cmd_is_ir), .cmd_ir(d1_cmd_ir), .cmd_dr(d1_cmd_dr), .rsp_valid(d1_rsp_valid),
    .rsp_dr(d1_rsp_dr), .tck(d1_tck), .tdi(d1_tdi), .tdo(1'b1), .ir_in(d1_ir_in),
    .ir_out(2'b00), .rsp_ir(d1_rsp_ir), .jtag_state_rti(d1_rti), .vs_uir(d1_vs_uir),
    .vs_cdr(d1_vs_cdr), .vs_sdr(d1_vs_sdr), .vs_udr(d1_vs_udr)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DRW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic           is_ir;
    logic [IRW-1:0] ir;
    logic [DRW-1:0] dr;
    logic [1:0]     tdo_mode;    // 0 loopback, 1 tdo=1, 2 tdo=0
    logic [IRW-1:0] ir_out;
    logic [IRW-1:0] exp_ir_in;
    logic [IRW-1:0] exp_rsp_ir;
    logic [DRW-1:0] exp_rsp_dr;
    int             exp_lat;
    int             exp_rises;
    int             exp_uir;
  } vec_t;

  vec_t vecs[6];
  vec_t post_rst;

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tck"}, 64'(tck), 64'd0);
    chk({tag, "_tdi"}, 64'(tdi), 64'd0);
    chk({tag, "_ir_in"}, 64'(ir_in), 64'd0);
    chk({tag, "_rsp_ir"}, 64'(rsp_ir), 64'd0);
    chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'd0);
    chk({tag, "_vs"}, 64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
    chk({tag, "_rti"}, 64'(rti), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
  endtask

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int c, rises, uir, nb;
    logic prev_tck, onehot_ok, busy_ok;
    logic [DRW-1:0] obs;
    @(negedge clk);
    cmd_is_ir = v.is_ir; cmd_ir = v.ir; cmd_dr = v.dr;
    ir_out = v.ir_out; tdo_mode = v.tdo_mode; cmd_valid = 1'b1;
    c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
    exp_q.push_back(v.exp_rsp_dr);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, "_ir_in_acc"}, 64'(ir_in), 64'(v.exp_ir_in));
    c = 1; rises = 0; uir = 0; nb = 0; obs = '0;
    prev_tck = tck; onehot_ok = 1'b1; busy_ok = 1'b1;
    while (!rsp_valid && c < 1000) begin
      if ($countones({rti, vs_uir, vs_cdr, vs_sdr, vs_udr}) != 1) onehot_ok = 1'b0;
      if (cmd_ready) busy_ok = 1'b0;
      if (vs_uir) uir++;
      if (vs_sdr && tck && !prev_tck) begin
        if (nb < DRW) obs[nb] = tdi;
        nb++;
        rises++;
      end
      prev_tck = tck;
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, 64'(c), 64'(v.exp_lat));
    chk({tag, "_sdr_rises"}, 64'(rises), 64'(v.exp_rises));
    chk({tag, "_uir_cycles"}, 64'(uir), 64'(v.exp_uir));
    chk({tag, "_onehot"}, 64'(onehot_ok), 64'd1);
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_rsp_ir"}, 64'(rsp_ir), 64'(v.exp_rsp_ir));
    chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(exp_q.pop_front()));
    chk({tag, "_ir_in_end"}, 64'(ir_in), 64'(v.exp_ir_in));
    if (!v.is_ir) chk({tag, "_tdi_seq"}, 64'(obs), 64'(v.dr));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_ready_after"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, rises, seen;
    logic prev_tck, busy_ok, onehot_ok;

    $display("scan master bench: sld_mfg_id=%0d sld_type_id=%0d", SLD_MFG_ID, SLD_TYPE_ID);

    //            is_ir ir     dr               mode  irout  ir_in  rsp_ir rsp_dr           lat  rise uir
    vecs[0] = '{1'b1, 2'b10, 38'h0,           2'd0, 2'b01, 2'b10, 2'b01, 38'h0,           5,   0,   4};
    vecs[1] = '{1'b0, 2'b00, 38'h2A_5555_AAAA, 2'd0, 2'b11, 2'b10, 2'b01, 38'h2A_5555_AAAA, 161, 38,  0};
    vecs[2] = '{1'b0, 2'b00, 38'h15_AAAA_5555, 2'd1, 2'b00, 2'b10, 2'b01, 38'h3F_FFFF_FFFF, 161, 38,  0};
    vecs[3] = '{1'b0, 2'b00, 38'h3F_FFFF_FFFF, 2'd2, 2'b10, 2'b10, 2'b01, 38'h0,           161, 38,  0};
    vecs[4] = '{1'b1, 2'b01, 38'h0,           2'd0, 2'b11, 2'b01, 2'b11, 38'h0,           5,   0,   4};
    vecs[5] = '{1'b0, 2'b00, 38'h00_0000_0001, 2'd0, 2'b00, 2'b01, 2'b11, 38'h00_0000_0001, 161, 38,  0};
    post_rst = '{1'b0, 2'b00, 38'h0F_0F0F_0F0F, 2'd0, 2'b01, 2'b00, 2'b00, 38'h0F_0F0F_0F0F, 161, 38,  0};

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_is_ir = 1'b0; cmd_ir = '0; cmd_dr = '0; ir_out = '0; tdo_mode = 2'd0;
    d1_cmd_valid = 1'b0; d1_cmd_is_ir = 1'b0; d1_cmd_ir = '0; d1_cmd_dr = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: DR then IR with cmd_valid never dropped.
    @(negedge clk);
    cmd_is_ir = 1'b0; cmd_dr = 38'h12_3456_789A; ir_out = 2'b10; tdo_mode = 2'd0; cmd_valid = 1'b1;
    c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    cmd_is_ir = 1'b1; cmd_ir = 2'b11;
    c = 1; busy_ok = 1'b1; onehot_ok = 1'b1;
    while (!rsp_valid && c < 1000) begin
      if (cmd_ready) busy_ok = 1'b0;
      if ($countones({rti, vs_uir, vs_cdr, vs_sdr, vs_udr}) != 1) onehot_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    chk("b2b_dr_latency", 64'(c), 64'd161);
    chk("b2b_busy", 64'(busy_ok), 64'd1);
    chk("b2b_onehot", 64'(onehot_ok), 64'd1);
    chk("b2b_rsp_dr", 64'(rsp_dr), 64'(38'h12_3456_789A));
    chk("b2b_ready_at_rsp", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("b2b_ready_next", 64'(cmd_ready), 64'd1);
    chk("b2b_ir_in_kept", 64'(ir_in), 64'(2'b01));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_ir_accepted", 64'(ir_in), 64'(2'b11));
    chk("b2b_uir_entered", 64'(vs_uir), 64'd1);
    c = 1;
    while (!rsp_valid && c < 100) begin @(negedge clk); c++; end
    chk("b2b_ir_latency", 64'(c), 64'd5);
    chk("b2b_rsp_ir", 64'(rsp_ir), 64'(2'b10));

    // Mid-scan reset at SDR bit 20.
    @(negedge clk);
    cmd_is_ir = 1'b0; cmd_dr = 38'h3F_0000_FFFF; tdo_mode = 2'd0; cmd_valid = 1'b1;
    c = 0;
    while (!cmd_ready && c < 50) begin @(negedge clk); c++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    c = 1; rises = 0; prev_tck = tck;
    while (rises < 20 && c < 1000) begin
      @(negedge clk);
      c++;
      if (vs_sdr && tck && !prev_tck) rises++;
      prev_tck = tck;
    end
    chk("mid_reached_bit20", 64'(rises), 64'd20);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("mid_rst");
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_ready_after", 64'(cmd_ready), 64'd1);
    seen = 0;
    repeat (200) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("mid_no_rsp", 64'(seen), 64'd0);
    run_vec(post_rst, "post_rst");

    // CLK_DIV=1 instance with tdo held high.
    @(negedge clk);
    d1_cmd_is_ir = 1'b0; d1_cmd_dr = 38'h12_3456_789A; d1_cmd_valid = 1'b1;
    c = 0;
    while (!d1_cmd_ready && c < 50) begin @(negedge clk); c++; end
    chk("div1_ready", 64'(d1_cmd_ready), 64'd1);
    @(negedge clk);
    d1_cmd_valid = 1'b0;
    c = 1;
    while (!d1_rsp_valid && c < 1000) begin @(negedge clk); c++; end
    chk("div1_latency", 64'(c), 64'd81);
    chk("div1_rsp_dr", 64'(d1_rsp_dr), 64'(38'h3F_FFFF_FFFF));
    chk("div1_rti_idle", 64'({d1_rti, d1_vs_uir, d1_vs_cdr, d1_vs_sdr, d1_vs_udr}), 64'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
